calc_sequencer: RTL

//  Command sequencer/ALU stage that drives the calculator's 4x3-bit register file.

---
 rtl/calc_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - command sequencer and ALU stage driving the calculator register file
//
// Takes one command per start pulse. It reads the source operands from the register
// file, computes the ALU result and writes that result back to the register file.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   start                     command valid; only looked at in IDLE
//   op, sa, sb, dst, imm      command fields (opcode, source A/B, destination, immediate)
//   rf_rea, rf_reb            register file read enables (high only in READ)
//   rf_raa, rf_rab            register file read addresses
//   rf_douta, rf_doutb        register file read data (combinational from the register file)
//   rf_we, rf_wa, rf_din      register file write port (active only in WRITE)
//   busy                      high in every state except IDLE
//   done                      one-cycle pulse when a command completes
//   result, ovf               last computed/loaded value and its carry/borrow flag

module calc_sequencer #(
    parameter int DW = 3,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] sa,
    input  logic [AW-1:0] sb,
    input  logic [AW-1:0] dst,
    input  logic [DW-1:0] imm,
    output logic          rf_rea,
    output logic          rf_reb,
    output logic [AW-1:0] rf_raa,
    output logic [AW-1:0] rf_rab,
    input  logic [DW-1:0] rf_douta,
    input  logic [DW-1:0] rf_doutb,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_din,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          ovf
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Latched command
    logic [2:0]    op_q;
    logic [AW-1:0] sa_q;
    logic [AW-1:0] sb_q;
    logic [AW-1:0] dst_q;
    logic [DW-1:0] imm_q;

    // Operands captured in READ, so a later write to dst==sa/sb cannot disturb them
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;

    // ALU
    logic [DW:0]   alu_sum;
    logic [DW-1:0] alu_res;
    logic          alu_ovf;

    always_comb begin
        alu_sum = {1'b0, opa} + {1'b0, opb};
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = alu_sum[DW-1:0];
                alu_ovf = alu_sum[DW];
            end
            OP_SUB: begin
                alu_res = opa - opb;
                alu_ovf = (opa < opb);
            end
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_MOV:  alu_res = opa;
            default: alu_res = '0;
        endcase
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
            dst_q  <= '0;
            imm_q  <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        sa_q  <= sa;
                        sb_q  <= sb;
                        dst_q <= dst;
                        imm_q <= imm;
                        if (op == OP_LOAD) begin
                            result <= imm;
                            ovf    <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    opa <= rf_douta;
                    opb <= rf_doutb;
                end
                S_EXEC: begin
                    result <= alu_res;
                    ovf    <= alu_ovf;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_LOAD)
                        state_nxt = S_WRITE;
                    else if (op == OP_NOP)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_READ;
                end
            end
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; everything is zero unless the state asks for it
    always_comb begin
        rf_rea = 1'b0;
        rf_reb = 1'b0;
        rf_raa = '0;
        rf_rab = '0;
        rf_we  = 1'b0;
        rf_wa  = '0;
        rf_din = '0;
        busy   = (state != S_IDLE);
        done   = 1'b0;
        case (state)
            S_READ: begin
                rf_rea = 1'b1;
                rf_reb = 1'b1;
                rf_raa = sa_q;
                rf_rab = sb_q;
            end
            S_WRITE: begin
                rf_we  = 1'b1;
                rf_wa  = dst_q;
                rf_din = result;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
